cpu_seq: RTL and testbench

//  Multi-cycle sequencer for the combinational decode/execute datapath. Owns the PC and the

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/cpu_seq_perf.sv | 23 ++
 rtl/cpu_seq.sv | 147 ++++++++++++++
 tb/tb_cpu_seq.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer: state encoding,
// memory opcodes and the default reset PC.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        FAULT = 3'd5
    } state_t;

    localparam logic [5:0]  OP_LW    = 6'b100011;
    localparam logic [5:0]  OP_SW    = 6'b101011;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // True when the opcode needs a data-memory access
    function automatic logic is_mem_op(input logic [5:0] opcode);
        return (opcode == OP_LW) || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/cpu_seq_perf.sv
// Performance counters for cpu_seq: retired instructions and memory stall
// cycles. Both counters wrap.
module cpu_seq_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        retire,
    input  logic        stall,
    output logic [31:0] perf_retired,
    output logic [31:0] perf_stall
);

    // Count retire pulses and cycles where memory holds off a request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_retired <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (retire) perf_retired <= perf_retired + 32'd1;
            if (stall)  perf_stall   <= perf_stall + 32'd1;
        end
    end

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle sequencer: owns PC and instruction register, shares one memory
// port between fetch and LW/SW, issues one rf_we/retire per instruction.
// Optional feature macro: CPU_SEQ_PERF_EN (adds live perf counters; when not
// defined the perf ports are tied to zero).
module cpu_seq #(
    parameter logic [31:0] RESET_PC    = cpu_pkg::RESET_PC,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic [31:0] load_data,
    input  logic [31:0] dec_mem_addr,
    input  logic        dec_wren,
    input  logic [31:0] dec_mem_wdata,
    input  logic        dec_wreg,
    input  logic        dec_is_jmp,
    input  logic [31:0] dec_jmp_addr,
    output logic        rf_we,
    output logic        retire,
    output logic        busy,
    output logic        fault,
    output logic [31:0] perf_retired,
    output logic [31:0] perf_stall
);
    import cpu_pkg::*;

    localparam logic        TIMEOUT_EN   = (MEM_TIMEOUT != 0);
    localparam logic [31:0] TIMEOUT_LAST = 32'(MEM_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg;
    logic [31:0] inst_reg;
    logic [31:0] load_data_reg;
    logic [31:0] wait_cnt_reg;
    logic        mem_stall;
    logic        timeout_hit;

    // A request is stalled when memory has not accepted it this cycle
    assign mem_stall   = mem_req && !mem_ready;
    // The current stall cycle would be the last one allowed
    assign timeout_hit = TIMEOUT_EN && (wait_cnt_reg == TIMEOUT_LAST);

    // Next-state and memory/writeback outputs, all decoded from the current state
    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        rf_we      = 1'b0;
        retire     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (run) state_next = FETCH;
            end
            FETCH: begin
                if (pc_reg[1:0] != 2'b00) begin
                    state_next = FAULT;
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = pc_reg;
                    if (mem_ready)        state_next = EXEC;
                    else if (timeout_hit) state_next = FAULT;
                end
            end
            EXEC: begin
                state_next = is_mem_op(inst_reg[31:26]) ? MEM : WB;
            end
            MEM: begin
                if (dec_mem_addr[1:0] != 2'b00) begin
                    state_next = FAULT;
                end else begin
                    mem_req   = 1'b1;
                    mem_addr  = dec_mem_addr;
                    mem_we    = dec_wren;
                    mem_wdata = dec_mem_wdata;
                    if (mem_ready)        state_next = WB;
                    else if (timeout_hit) state_next = FAULT;
                end
            end
            WB: begin
                rf_we      = dec_wreg;
                retire     = 1'b1;
                state_next = run ? FETCH : IDLE;
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = FAULT;
            end
        endcase
    end

    // State, PC, instruction/load capture and the per-access wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            pc_reg        <= RESET_PC;
            inst_reg      <= 32'd0;
            load_data_reg <= 32'd0;
            wait_cnt_reg  <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == FETCH && mem_req && mem_ready)
                inst_reg <= mem_rdata;
            if (state_reg == MEM && mem_req && mem_ready && inst_reg[31:26] == OP_LW)
                load_data_reg <= mem_rdata;
            if (state_reg == WB)
                pc_reg <= dec_is_jmp ? dec_jmp_addr : pc_reg + 32'd4;
            if (state_next != state_reg)
                wait_cnt_reg <= 32'd0;
            else if (mem_stall && TIMEOUT_EN)
                wait_cnt_reg <= wait_cnt_reg + 32'd1;
        end
    end

    assign pc        = pc_reg;
    assign inst      = inst_reg;
    assign load_data = load_data_reg;
    assign busy      = (state_reg != IDLE) && (state_reg != FAULT);
    assign fault     = (state_reg == FAULT);

`ifdef CPU_SEQ_PERF_EN
    cpu_seq_perf u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .retire       (retire),
        .stall        (mem_stall),
        .perf_retired (perf_retired),
        .perf_stall   (perf_stall)
    );
`else
    assign perf_retired = 32'd0;
    assign perf_stall   = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_seq.sv
// Self-checking bench for cpu_seq: a table of instructions plays the role of
// decode and memory; expectations go through a scoreboard queue and are
// compared when the sequencer retires. Hand sequences cover run-drop,
// misaligned jump, fetch timeout and reset mid-access.
module tb_cpu_seq;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic [31:0] pc, inst, load_data;
    logic [31:0] dec_mem_addr = 32'd0;
    logic        dec_wren = 1'b0;
    logic [31:0] dec_mem_wdata = 32'd0;
    logic        dec_wreg = 1'b0;
    logic        dec_is_jmp = 1'b0;
    logic [31:0] dec_jmp_addr = 32'd0;
    logic        rf_we, retire, busy, fault;
    logic [31:0] perf_retired, perf_stall;

    always #5 clk = ~clk;

    cpu_seq #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .inst(inst), .load_data(load_data),
        .dec_mem_addr(dec_mem_addr), .dec_wren(dec_wren), .dec_mem_wdata(dec_mem_wdata),
        .dec_wreg(dec_wreg), .dec_is_jmp(dec_is_jmp), .dec_jmp_addr(dec_jmp_addr),
        .rf_we(rf_we), .retire(retire), .busy(busy), .fault(fault),
        .perf_retired(perf_retired), .perf_stall(perf_stall)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    int          fetch_delay = 0, data_delay = 0, wait_ctr = 0;
    logic        in_data = 1'b0;
    logic [31:0] fetch_val = 32'd0, load_val = 32'd0;
    int          data_req_cycles = 0, stall_total = 0;
    logic [31:0] seen_fetch_addr = 32'd1, seen_data_addr = 32'd1, seen_wdata = 32'd0;
    logic        seen_we = 1'b0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'd0, prev_wdata = 32'd0;

    always @(negedge clk) begin
        if (mem_req) begin
            if (prev_wait) begin
                check("hold_addr", mem_addr, prev_addr);
                check("hold_wdata", mem_wdata, prev_wdata);
            end
            if (in_data) begin
                data_req_cycles++;
                seen_data_addr = mem_addr;
                seen_we        = mem_we;
                seen_wdata     = mem_wdata;
            end else begin
                seen_fetch_addr = mem_addr;
            end
            if (wait_ctr >= (in_data ? data_delay : fetch_delay)) begin
                mem_ready = 1'b1;
                mem_rdata = in_data ? load_val : fetch_val;
                prev_wait = 1'b0;
                in_data   = 1'b1;
                wait_ctr  = 0;
            end else begin
                mem_ready  = 1'b0;
                mem_rdata  = 32'hBAD0_BAD0;
                wait_ctr++;
                stall_total++;
                prev_wait  = 1'b1;
                prev_addr  = mem_addr;
                prev_wdata = mem_wdata;
            end
        end else begin
            mem_ready = 1'b0;
            prev_wait = 1'b0;
        end
    end

    // ---------------- vectors and scoreboard ----------------
    typedef struct {
        logic [31:0] inst;
        logic        is_mem;
        logic        wren;
        logic        wreg;
        logic        jmp;
        logic [31:0] jaddr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] ldata;
        int          fd;
        int          dd;
        logic [31:0] pc_in;
        logic [31:0] pc_out;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic        rf_we;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_load = 32'd0;
    int          n_retired = 0;

    task automatic run_instr(input vec_t v, input bit drop_run);
        exp_t e;
        exp_t got_e;
        int   lat;
        bit   got;
        logic [31:0] retired_before;
        dec_mem_addr   = v.daddr;
        dec_wren       = v.wren;
        dec_mem_wdata  = v.wdata;
        dec_wreg       = v.wreg;
        dec_is_jmp     = v.jmp;
        dec_jmp_addr   = v.jaddr;
        fetch_val      = v.inst;
        load_val       = v.ldata;
        fetch_delay    = v.fd;
        data_delay     = v.dd;
        in_data        = 1'b0;
        wait_ctr       = 0;
        data_req_cycles = 0;
        seen_fetch_addr = 32'd1;
        retired_before = perf_retired;
        run            = 1'b1;
        e.inst  = v.inst;
        e.rf_we = v.wreg;
        e.lat   = (v.is_mem ? 4 : 3) + v.fd + v.dd;
        exp_q.push_back(e);
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (busy) lat++;
            if (drop_run && mem_req && in_data) run = 1'b0;
            if (retire) begin
                got   = 1'b1;
                got_e = exp_q.pop_front();
                check("rf_we", {31'd0, rf_we}, {31'd0, got_e.rf_we});
                check("inst", inst, got_e.inst);
                check("latency", lat, got_e.lat);
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL retire_timeout: no retire for inst %h", v.inst);
            void'(exp_q.pop_front());
            return;
        end
        n_retired++;
        @(posedge clk);
        #1;
        if (v.is_mem && !v.wren) exp_load = v.ldata;
        check("pc_next", pc, v.pc_out);
        check("fetch_addr", seen_fetch_addr, v.pc_in);
        check("load_data", load_data, exp_load);
        if (v.is_mem) begin
            check("data_addr", seen_data_addr, v.daddr);
            check("data_cycles", data_req_cycles, v.dd + 1);
            check("data_we", {31'd0, seen_we}, {31'd0, v.wren});
            if (v.wren) check("store_data", seen_wdata, v.wdata);
        end
        if (drop_run) begin
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_req", {31'd0, mem_req}, 32'd0);
`ifdef CPU_SEQ_PERF_EN
            check("perf_retired_inc", perf_retired, retired_before + 32'd1);
`endif
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        run = 1'b0;
        #1;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_load", load_data, 32'd0);
        check("rst_strobes", {30'd0, rf_we, retire}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_load = 32'd0;
    endtask

    vec_t vecs[9];
    vec_t v;
    int   cnt;

    initial begin
        //            inst          mem   wren  wreg  jmp   jaddr          daddr        wdata          ldata          fd dd pc_in          pc_out
        vecs[0] = '{32'h00221821, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,       32'h0,         32'h0,         0, 0, 32'h0,         32'h4};
        vecs[1] = '{32'h8C430008, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h100,     32'h0,         32'hDEADBEEF,  0, 2, 32'h4,         32'h8};
        vecs[2] = '{32'hAC430010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h104,     32'h12345678,  32'h55555555,  1, 0, 32'h8,         32'hC};
        vecs[3] = '{32'h1000000F, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40,        32'h0,       32'h0,         32'h0,         0, 0, 32'hC,         32'h40};
        vecs[4] = '{32'h00221821, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,       32'h0,         32'h0,         3, 0, 32'h40,        32'h44};
        vecs[5] = '{32'h14220003, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,       32'h0,         32'h0,         0, 0, 32'h44,        32'h48};
        vecs[6] = '{32'h0BFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC,  32'h0,       32'h0,         32'h0,         0, 0, 32'h48,        32'hFFFFFFFC};
        vecs[7] = '{32'h00221821, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,       32'h0,         32'h0,         0, 0, 32'hFFFFFFFC,  32'h0};
        vecs[8] = '{32'h8C450000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'h200,     32'h0,         32'h0BADF00D,  0, 0, 32'h0,         32'h4};

        do_reset();
        @(negedge clk);
        check("idle_busy0", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 9; i++) run_instr(vecs[i], 1'b0);

        // SW with run dropped while the store waits in MEM
        v = '{32'hAC460020, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h300, 32'hCAFEF00D, 32'h0, 0, 2, 32'h4, 32'h8};
        run_instr(v, 1'b1);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (retire || rf_we || busy || mem_req) cnt++;
        end
        check("idle_quiet", cnt, 0);

`ifdef CPU_SEQ_PERF_EN
        check("perf_retired", perf_retired, n_retired);
        check("perf_stall", perf_stall, stall_total);
`else
        check("perf_retired_tied", perf_retired, 32'd0);
        check("perf_stall_tied", perf_stall, 32'd0);
`endif

        // Jump to a misaligned target: next fetch must fault without a request
        v = '{32'h08000010, 1'b0, 1'b0, 1'b0, 1'b1, 32'h42, 32'h0, 32'h0, 32'h0, 0, 0, 32'h8, 32'h42};
        run_instr(v, 1'b0);
        @(negedge clk);
        check("misalign_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        check("misalign_fault", {31'd0, fault}, 32'd1);
        check("misalign_busy", {31'd0, busy}, 32'd0);

        // Fetch never acknowledged: fault after MEM_TIMEOUT wait cycles
        do_reset();
        fetch_delay = 1000;
        in_data     = 1'b0;
        wait_ctr    = 0;
        run         = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20 && !fault; c++) begin
            @(negedge clk);
            if (mem_req) cnt++;
        end
        check("timeout_waits", cnt, 4);
        check("timeout_fault", {31'd0, fault}, 32'd1);
        check("timeout_req", {31'd0, mem_req}, 32'd0);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (fault && !mem_req && !retire) cnt++;
        end
        check("fault_sticky", cnt, 6);

        // Reset asserted in the middle of a waiting fetch
        do_reset();
        check("fault_cleared", {31'd0, fault}, 32'd0);
        fetch_delay = 1000;
        in_data     = 1'b0;
        wait_ctr    = 0;
        run         = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_req", {31'd0, mem_req}, 32'd0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (retire || rf_we || mem_req) cnt++;
        end
        check("rst_no_strobe", cnt, 0);
        run = 1'b0;
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
